// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: ALUOp codes, forwarding selects, payload struct.
package id_ex_stage_pkg;

   localparam int unsigned W       = 32;
   localparam int unsigned RA_W    = 5;
   localparam int unsigned OP_W    = 5;
   localparam int unsigned SHAMT_W = 5;

   // Shared ALUOp encoding
   localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
   localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
   localparam logic [OP_W-1:0] ALU_AND  = 5'd2;
   localparam logic [OP_W-1:0] ALU_OR   = 5'd3;
   localparam logic [OP_W-1:0] ALU_XOR  = 5'd4;
   localparam logic [OP_W-1:0] ALU_NOR  = 5'd5;
   localparam logic [OP_W-1:0] ALU_SLT  = 5'd6;
   localparam logic [OP_W-1:0] ALU_SLTU = 5'd7;
   localparam logic [OP_W-1:0] ALU_SLL  = 5'd8;
   localparam logic [OP_W-1:0] ALU_SRL  = 5'd9;
   localparam logic [OP_W-1:0] ALU_SRA  = 5'd10;
   localparam logic [OP_W-1:0] ALU_LUI  = 5'd11;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_e;

   localparam logic [RA_W-1:0] REG_ZERO = '0;

   // Everything the ID/EX register carries into EX
   typedef struct packed {
      logic               valid;
      logic [W-1:0]       pc;
      logic [W-1:0]       rs_data;
      logic [W-1:0]       rt_data;
      logic [W-1:0]       imm;
      logic [SHAMT_W-1:0] shamt;
      logic [RA_W-1:0]    rs;
      logic [RA_W-1:0]    rt;
      logic [RA_W-1:0]    rd;
      logic [OP_W-1:0]    aluop;
      logic               asel_shamt;
      logic               bsel_imm;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               memtoreg;
   } id_ex_t;

   // Pick the youngest in-flight producer of src; $0 always reads the register file
   function automatic fwd_sel_e fwd_select(
      input logic [RA_W-1:0] src,
      input logic            exmem_rw,
      input logic [RA_W-1:0] exmem_rd,
      input logic            memwb_rw,
      input logic [RA_W-1:0] memwb_rd
   );
      fwd_sel_e sel;
      sel = FWD_RF;
      if (src != REG_ZERO) begin
         if (exmem_rw && (exmem_rd == src)) begin
            sel = FWD_EXMEM;
         end else if (memwb_rw && (memwb_rd == src)) begin
            sel = FWD_MEMWB;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding select generation for the two EX source operands.
module fwd_unit
   import id_ex_stage_pkg::*;
(
   input  logic [RA_W-1:0] ex_rs,
   input  logic [RA_W-1:0] ex_rt,
   input  logic            exmem_regwrite,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic            memwb_regwrite,
   input  logic [RA_W-1:0] memwb_rd,
   output fwd_sel_e        fwd_a_sel,
   output fwd_sel_e        fwd_b_sel
);

   // EX/MEM outranks MEM/WB because it holds the younger result
   always_comb begin
      fwd_a_sel = fwd_select(ex_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
      fwd_b_sel = fwd_select(ex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX operand forwarding.
module id_ex_stage
   import id_ex_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [W-1:0]       id_pc,
   input  logic [W-1:0]       id_rs_data,
   input  logic [W-1:0]       id_rt_data,
   input  logic [W-1:0]       id_imm,
   input  logic [SHAMT_W-1:0] id_shamt,
   input  logic [RA_W-1:0]    id_rs,
   input  logic [RA_W-1:0]    id_rt,
   input  logic [RA_W-1:0]    id_rd,
   input  logic               id_uses_rs,
   input  logic               id_uses_rt,
   input  logic [OP_W-1:0]    id_aluop,
   input  logic               id_asel_shamt,
   input  logic               id_bsel_imm,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_memtoreg,
   input  logic               exmem_regwrite,
   input  logic [RA_W-1:0]    exmem_rd,
   input  logic [W-1:0]       exmem_result,
   input  logic               memwb_regwrite,
   input  logic [RA_W-1:0]    memwb_rd,
   input  logic [W-1:0]       memwb_result,
   output logic               load_use_stall,
   output logic [W-1:0]       alu_a,
   output logic [W-1:0]       alu_b,
   output logic [OP_W-1:0]    ex_aluop,
   output logic               ex_valid,
   output logic [W-1:0]       ex_pc,
   output logic [W-1:0]       ex_store_data,
   output logic [RA_W-1:0]    ex_rd,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_memtoreg
);

   id_ex_t   ex_q, ex_d, id_pkt;
   fwd_sel_e fwd_a_sel, fwd_b_sel;
   logic [W-1:0] fwd_rs, fwd_rt;

   // A load in EX whose result the ID instruction needs cannot be forwarded in time
   always_comb begin
      load_use_stall = ex_q.valid & ex_q.memread & (ex_q.rd != REG_ZERO) & id_valid &
                       ((id_uses_rs & (id_rs == ex_q.rd)) | (id_uses_rt & (id_rt == ex_q.rd)));
   end

   // Next ID/EX contents: flush > stall > load-use bubble > normal capture
   always_comb begin
      id_pkt            = '0;
      id_pkt.valid      = id_valid;
      id_pkt.pc         = id_pc;
      id_pkt.rs_data    = id_rs_data;
      id_pkt.rt_data    = id_rt_data;
      id_pkt.imm        = id_imm;
      id_pkt.shamt      = id_shamt;
      id_pkt.rs         = id_rs;
      id_pkt.rt         = id_rt;
      id_pkt.rd         = id_rd;
      id_pkt.aluop      = id_aluop;
      id_pkt.asel_shamt = id_asel_shamt;
      id_pkt.bsel_imm   = id_bsel_imm;
      id_pkt.regwrite   = id_regwrite & id_valid;
      id_pkt.memread    = id_memread  & id_valid;
      id_pkt.memwrite   = id_memwrite & id_valid;
      id_pkt.memtoreg   = id_memtoreg & id_valid;

      ex_d = ex_q;
      if (flush) begin
         ex_d = '0;
      end else if (stall) begin
         ex_d = ex_q;
      end else if (load_use_stall) begin
         ex_d = '0;
      end else begin
         ex_d = id_pkt;
      end
   end

   // ID/EX register
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   fwd_unit u_fwd (
      .ex_rs          (ex_q.rs),
      .ex_rt          (ex_q.rt),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .fwd_a_sel      (fwd_a_sel),
      .fwd_b_sel      (fwd_b_sel)
   );

   // Forwarded operands and ALU input selection
   always_comb begin
      fwd_rs = ex_q.rs_data;
      fwd_rt = ex_q.rt_data;
      case (fwd_a_sel)
         FWD_EXMEM: fwd_rs = exmem_result;
         FWD_MEMWB: fwd_rs = memwb_result;
         default:   fwd_rs = ex_q.rs_data;
      endcase
      case (fwd_b_sel)
         FWD_EXMEM: fwd_rt = exmem_result;
         FWD_MEMWB: fwd_rt = memwb_result;
         default:   fwd_rt = ex_q.rt_data;
      endcase
      alu_a         = ex_q.asel_shamt ? W'(ex_q.shamt) : fwd_rs;
      alu_b         = ex_q.bsel_imm ? ex_q.imm : fwd_rt;
      ex_store_data = fwd_rt;
   end

   assign ex_aluop    = ex_q.aluop;
   assign ex_valid    = ex_q.valid;
   assign ex_pc       = ex_q.pc;
   assign ex_rd       = ex_q.rd;
   assign ex_regwrite = ex_q.regwrite;
   assign ex_memread  = ex_q.memread;
   assign ex_memwrite = ex_q.memwrite;
   assign ex_memtoreg = ex_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a per-cycle reference model and literal spot checks.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        id_valid;
   logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt;
   logic [4:0]  id_aluop;
   logic        id_asel_shamt, id_bsel_imm;
   logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        load_use_stall;
   logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
   logic [4:0]  ex_aluop, ex_rd;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_aluop(id_aluop),
      .id_asel_shamt(id_asel_shamt), .id_bsel_imm(id_bsel_imm),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_memtoreg(id_memtoreg),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .load_use_stall(load_use_stall), .alu_a(alu_a), .alu_b(alu_b), .ex_aluop(ex_aluop),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg)
   );

   always #5 clk = ~clk;

   // Model of the instruction currently sitting in EX
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs_data, rt_data, imm;
      logic [4:0]  shamt, rs, rt, rd, aluop;
      logic        asel, bsel, rw, mr, mw, mtr;
   } ex_model_t;

   ex_model_t m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // The EX instruction is a load that writes a register the ID instruction reads
   function automatic logic hazard();
      if (!(m.valid && m.mr && m.rd != 5'd0 && id_valid)) return 1'b0;
      return (id_uses_rs && id_rs == m.rd) || (id_uses_rt && id_rt == m.rd);
   endfunction

   // Architectural value of register r as EX should see it: oldest value first, younger writers overwrite
   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
      logic [31:0] v;
      v = rf;
      if (memwb_regwrite && memwb_rd == r) v = memwb_result;
      if (exmem_regwrite && exmem_rd == r) v = exmem_result;
      if (r == 5'd0) v = rf;
      return v;
   endfunction

   function automatic ex_model_t from_id();
      ex_model_t t;
      t.valid = id_valid;  t.pc = id_pc;  t.rs_data = id_rs_data;  t.rt_data = id_rt_data;
      t.imm = id_imm;  t.shamt = id_shamt;  t.rs = id_rs;  t.rt = id_rt;  t.rd = id_rd;
      t.aluop = id_aluop;  t.asel = id_asel_shamt;  t.bsel = id_bsel_imm;
      t.rw = id_regwrite && id_valid;  t.mr = id_memread && id_valid;
      t.mw = id_memwrite && id_valid;  t.mtr = id_memtoreg && id_valid;
      return t;
   endfunction

   // Model update at each edge
   always @(posedge clk) begin
      if (rst || flush)      m <= '0;
      else if (stall)        m <= m;
      else if (hazard())     m <= '0;
      else                   m <= from_id();
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("load_use_stall", 32'(load_use_stall), 32'(hazard()));
         chk("ex_valid",    32'(ex_valid),    32'(m.valid));
         chk("ex_pc",       ex_pc,            m.pc);
         chk("ex_rd",       32'(ex_rd),       32'(m.rd));
         chk("ex_aluop",    32'(ex_aluop),    32'(m.aluop));
         chk("ex_regwrite", 32'(ex_regwrite), 32'(m.rw));
         chk("ex_memread",  32'(ex_memread),  32'(m.mr));
         chk("ex_memwrite", 32'(ex_memwrite), 32'(m.mw));
         chk("ex_memtoreg", 32'(ex_memtoreg), 32'(m.mtr));
         if (m.valid) begin
            chk("alu_a", alu_a, m.asel ? {27'd0, m.shamt} : operand(m.rs, m.rs_data));
            chk("alu_b", alu_b, m.bsel ? m.imm : operand(m.rt, m.rt_data));
            chk("ex_store_data", ex_store_data, operand(m.rt, m.rt_data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic clear_id();
      id_valid = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0; id_aluop = ALU_ADD;
      id_asel_shamt = 0; id_bsel_imm = 0;
      id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
   endtask

   task automatic clear_fwd();
      exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   initial begin
      clear_id();
      clear_fwd();
      stall = 0; flush = 0;

      // Reset with a live instruction presented
      rst = 1; id_valid = 1; id_regwrite = 1; id_pc = 32'h0040_0000;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst ex_valid", 32'(ex_valid), 32'd0);
      chk("rst ex_regwrite", 32'(ex_regwrite), 32'd0);
      chk("rst ex_pc", ex_pc, 32'd0);

      // First capture after reset
      rst = 0; id_pc = 32'h0040_0004;
      tick();
      chk("first pc", ex_pc, 32'h0040_0004);
      chk("first valid", 32'(ex_valid), 32'd1);

      // EX/MEM beats MEM/WB on rs=$8
      clear_id();
      id_valid = 1; id_pc = 32'h0040_0008; id_rs = 8; id_rs_data = 32'h1; id_rt = 9;
      id_rt_data = 32'h2; id_rd = 3; id_uses_rs = 1; id_uses_rt = 1; id_regwrite = 1;
      tick();
      stall = 1;
      exmem_regwrite = 1; exmem_rd = 8; exmem_result = 32'h1234;
      memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'h9999;
      #1 chk("exmem prio", alu_a, 32'h1234);
      exmem_rd = 5;
      #1 chk("memwb fwd", alu_a, 32'h9999);
      memwb_rd = 5;
      #1 chk("rf no fwd", alu_a, 32'h1);
      tick();

      // $0 is never forwarded
      stall = 0; clear_fwd();
      id_pc = 32'h0040_000C; id_rs = 0; id_rs_data = 0;
      tick();
      stall = 1;
      exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'h1234;
      memwb_regwrite = 1; memwb_rd = 0; memwb_result = 32'h9999;
      #1 chk("r0 no fwd", alu_a, 32'h0);
      tick();

      // sw: B takes imm, store data forwarded from MEM/WB
      stall = 0; clear_fwd(); clear_id();
      id_valid = 1; id_pc = 32'h0040_0010; id_rs = 4; id_rs_data = 32'h1000; id_rt = 9;
      id_rt_data = 32'h77; id_imm = 32'h10; id_bsel_imm = 1; id_memwrite = 1;
      id_uses_rs = 1; id_uses_rt = 1;
      tick();
      stall = 1;
      memwb_regwrite = 1; memwb_rd = 9; memwb_result = 32'hDEAD_BEEF;
      #1 chk("sw alu_b", alu_b, 32'h10);
      chk("sw store", ex_store_data, 32'hDEAD_BEEF);
      chk("sw alu_a", alu_a, 32'h1000);
      tick();

      // Load-use: lw $10 then add using $10
      stall = 0; clear_fwd(); clear_id();
      id_valid = 1; id_pc = 32'h0040_0014; id_rs = 2; id_rs_data = 32'h2000; id_imm = 32'h4;
      id_bsel_imm = 1; id_rd = 10; id_uses_rs = 1; id_regwrite = 1; id_memread = 1;
      id_memtoreg = 1;
      tick();
      clear_id();
      id_valid = 1; id_pc = 32'h0040_0018; id_rs = 10; id_rs_data = 32'h0; id_rt = 11;
      id_rt_data = 32'h5; id_rd = 12; id_uses_rs = 1; id_uses_rt = 1; id_regwrite = 1;
      #1 chk("lu stall", 32'(load_use_stall), 32'd1);
      tick();
      chk("lu bubble valid", 32'(ex_valid), 32'd0);
      chk("lu bubble rw", 32'(ex_regwrite), 32'd0);
      chk("lu bubble mr", 32'(ex_memread), 32'd0);
      chk("lu released", 32'(load_use_stall), 32'd0);
      exmem_regwrite = 1; exmem_rd = 10; exmem_result = 32'hABCD;
      tick();
      chk("lu add valid", 32'(ex_valid), 32'd1);
      chk("lu add pc", ex_pc, 32'h0040_0018);
      chk("lu add fwd", alu_a, 32'hABCD);

      // Stall holds for 3 cycles, then stall+flush bubbles
      clear_fwd(); clear_id();
      id_valid = 1; id_pc = 32'h0000_0100; id_rd = 4; id_regwrite = 1;
      tick();
      stall = 1; id_pc = 32'h0000_0200; id_rd = 7;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall pc", ex_pc, 32'h0000_0100);
         chk("stall rd", 32'(ex_rd), 32'd4);
      end
      flush = 1;
      tick();
      chk("flush valid", 32'(ex_valid), 32'd0);
      chk("flush pc", ex_pc, 32'd0);
      flush = 0; stall = 0;

      // sll $6, $7, 5 with $7 forwarded
      clear_id();
      id_valid = 1; id_pc = 32'h0040_0020; id_rt = 7; id_shamt = 5; id_asel_shamt = 1;
      id_aluop = ALU_SLL; id_rd = 6; id_uses_rt = 1; id_regwrite = 1;
      tick();
      stall = 1;
      exmem_regwrite = 1; exmem_rd = 7; exmem_result = 32'h3;
      #1 chk("sll alu_a", alu_a, 32'h5);
      chk("sll alu_b", alu_b, 32'h3);
      chk("sll aluop", 32'(ex_aluop), 32'd8);
      tick();

      // Flush alone, then reset mid-run
      stall = 0; flush = 1;
      tick();
      chk("flush only", 32'(ex_valid), 32'd0);
      flush = 0;
      tick();
      rst = 1;
      tick();
      chk("mid rst", 32'(ex_valid), 32'd0);
      rst = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register plus EX-side operand selection for the 5-stage MIPS pipeline. It captures decoded operands and controls from ID, resolves EX/MEM and MEM/WB forwarding, and drives the A/B/ALUOp inputs of the EX-stage ALU. It also detects load-use hazards and inserts bubbles. It carries store data and writeback controls onward to EX/MEM.

Parameters:
W, 32, datapath width
RA_W, 5, register-address width
OP_W, 5, ALUOp width (matches shared ALUOp encoding)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall  in  1  external hold; keep ID/EX contents unchanged
flush  in  1  replace next ID/EX contents with a bubble (branch taken / exception)
id_valid  in  1  ID holds a real instruction
id_pc  in  W  PC of the ID instruction
id_rs_data, id_rt_data  in  W  register-file read data
id_imm  in  W  already-extended immediate
id_shamt  in  5  instr[10:6]
id_rs, id_rt, id_rd  in  RA_W  source registers; destination register (already muxed rt/rd/31)
id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt
id_aluop  in  OP_W  ALU operation
id_asel_shamt  in  1  1: A = zero-extended shamt (sll/srl/sra)
id_bsel_imm  in  1  1: B = imm
id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  stage controls
exmem_regwrite  in  1  EX/MEM writes a register
exmem_rd  in  RA_W  EX/MEM destination
exmem_result  in  W  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB writes a register
memwb_rd  in  RA_W  MEM/WB destination
memwb_result  in  W  MEM/WB writeback value
load_use_stall  out  1  combinational; upstream must hold PC and IF/ID
alu_a, alu_b  out  W  ALU operands
ex_aluop  out  OP_W  ALU operation
ex_valid  out  1  EX holds a real instruction
ex_pc  out  W  PC of the EX instruction
ex_store_data  out  W  forwarded rt value for sw
ex_rd  out  RA_W  EX destination register
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered controls

Behaviour:
- Register update on rising clk edge. Priority order: rst > flush > stall > load_use_stall (load bubble) > normal load.
- rst: all registered fields cleared to 0. ex_valid=0, all controls 0, ex_aluop=0, ex_rd=0, ex_pc=0.
- flush: registers a bubble: valid and all four controls forced to 0, other fields zeroed. flush wins over stall in the same cycle.
- stall (without flush): every field holds its value. Forwarding outputs still recompute from the current exmem/memwb inputs.
- load_use_stall = ex_valid & ex_memread & ex_rd!=0 & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - When load_use_stall is asserted without stall or flush, the block loads a bubble; the ID instruction is re-presented next cycle.
- Normal load: every id_* field is captured. Captured valid = id_valid. Controls are ANDed with id_valid.
- Forwarding (combinational, on registered rs/rt), per source s ∈ {rs, rt}:
  - EX/MEM match (exmem_regwrite & exmem_rd!=0 & exmem_rd==s) selects exmem_result.
  - Otherwise a MEM/WB match (same rule) selects memwb_result.
  - Otherwise the registered register-file data is used.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- alu_a = asel_shamt ? {27'b0, shamt} : fwd_rs. Variable shifts use fwd_rs, and the ALU consumes A[4:0].
- alu_b = bsel_imm ? imm : fwd_rt. ex_store_data = fwd_rt regardless of bsel_imm.
- Latency: ID inputs appear at the ALU inputs one cycle later. Forwarding adds zero cycles.
- A bubble in EX still drives alu_a/alu_b (value irrelevant). Downstream gates side effects by ex_valid and the zeroed controls.

Decomposition:
- Shared package / define file holds:
  - ALUOp codes (existing encoding, OP_W=5).
  - Forwarding select encoding: FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - Register-0 constant.
- Sub-module fwd_unit:
  - Inputs: ex_rs, ex_rt, exmem_regwrite/exmem_rd, memwb_regwrite/memwb_rd.
  - Outputs: fwd_a_sel, fwd_b_sel (2 bits each), purely combinational.
- Pipeline register and hazard logic stay in id_ex_stage.

Test Plan:
- Reset and bubble:
  - rst=1 for 2 cycles with id_valid=1, id_regwrite=1 -> ex_valid=0, ex_regwrite=0, ex_pc=0.
  - Release rst -> next edge captures id_pc=0x0040_0004.
- EX/MEM forwarding:
  - Setup: EX holds add rs=$8 (rf 0x1), exmem_regwrite=1, exmem_rd=8, exmem_result=0x1234; memwb_rd=8, memwb_result=0x9999.
  - Required: alu_a=0x1234 (EX/MEM priority).
  - Same with exmem_rd=0, rs=$0 -> alu_a=0.
- MEM/WB forwarding and store data:
  - Setup: sw with rt=$9, memwb_regwrite=1, memwb_rd=9, memwb_result=0xDEAD_BEEF, bsel_imm=1, imm=0x10.
  - Required: alu_b=0x10, ex_store_data=0xDEAD_BEEF.
- Load-use:
  - Setup: EX holds lw rd=$10 (ex_memread=1), ID holds add rs=$10, uses_rs=1.
  - Required: load_use_stall=1; next edge ex_valid=0, controls 0.
  - Following cycle: add enters EX and forwards from EX/MEM.
- Stall vs flush:
  - stall=1 for 3 cycles -> all ex_* unchanged.
  - stall=1 and flush=1 together -> bubble loaded (ex_valid=0).
- Shift operand: sll with shamt=5, rt fwd=0x3 -> alu_a=0x0000_0005, alu_b=0x3, ex_aluop=ALUOp_SLL.
